// File: rtl/capture_ctrl_pkg.sv
// capture_ctrl_pkg
// Shared definitions for the capture sequencer: the state encoding, the
// granularity of the size fields and where those fields sit inside the
// 32-bit configuration word. Also provides a helper that turns a size field
// into the number of samples it stands for.
// No ports; imported by capture_cnt and capture_ctrl.

package capture_ctrl_pkg;

   // Sequencer states, 3-bit encoding.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SAMPLE  = 3'd1,
      ST_DELAY   = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_SEND = 3'd4,
      ST_RD_WAIT = 3'd5
   } state_t;

   // Size fields count in units of this many samples.
   localparam int SAMPLES_PER_UNIT = 4;

   // Bit offsets of the read (R) and delay (D) fields in config_data.
   localparam int CFG_READ_LSB  = 0;
   localparam int CFG_DELAY_LSB = 16;

   // Number of samples described by a size field: (field + 1) * 4.
   function automatic logic [31:0] windowLength(input logic [15:0] field);
      return (32'(field) + 32'd1) * 32'(SAMPLES_PER_UNIT);
   endfunction

endpackage

// File: rtl/capture_cnt.sv
// capture_cnt
// Down-counter used by the capture sequencer for both the post-trigger delay
// and the readback length. It holds "events remaining minus one", so the
// event seen while zero is asserted is the final one; this lets a full
// (2^CW)*4 window fit in W = CW+2 bits.
// Ports:
//   clock      in  core clock
//   reset      in  asynchronous active-high reset
//   load       in  load loadValue (wins over decrement)
//   loadValue  in  W-bit value to load
//   decrement  in  count down by one (saturates at zero)
//   zero       out counter currently holds zero

module capture_cnt
   import capture_ctrl_pkg::*;
#(
   parameter int W = 18
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] loadValue,
   input  logic         decrement,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: a load always wins; decrement never wraps below zero so a
   // stray decrement at the end of a window cannot restart it.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = loadValue;
      end else if (decrement && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   // Count register, cleared asynchronously.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl
// Capture sequencer: while armed, writes the incoming sample stream into an
// external sample RAM used as a ring buffer, counts a programmable
// post-trigger window after run, then reads the captured window back
// oldest-first through a send/busy handshake.
// Optional feature macro: CAPTURE_CTRL_ABORT_EN adds the finish_now port,
// which ends a capture early and goes straight to readback.
// Ports:
//   clock, reset         core clock, asynchronous active-high reset
//   arm                  start capturing (taken in IDLE only)
//   run                  trigger, level-sampled in SAMPLE
//   finish_now           abort capture (only with CAPTURE_CTRL_ABORT_EN)
//   wrSize, config_data  load read field R [CW-1:0] and delay field D [16+CW-1:16]
//   validIn, dataIn      sample strobe and value
//   busy                 transmitter busy
//   send                 memory read data is valid for the transmitter
//   memoryWrData         registered write data
//   memoryAddr           shared RAM address for reads and writes
//   memoryWrite          write strobe
//   memoryRead           read strobe, RAM data follows one cycle later
//   memoryLastWrite      flags the final post-trigger write
//   capturing            high in SAMPLE or DELAY

module capture_ctrl
   import capture_ctrl_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 6,
   parameter int CW = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          arm,
   input  logic          run,
`ifdef CAPTURE_CTRL_ABORT_EN
   input  logic          finish_now,
`endif
   input  logic          wrSize,
   input  logic [31:0]   config_data,
   input  logic          validIn,
   input  logic [DW-1:0] dataIn,
   input  logic          busy,
   output logic          send,
   output logic [DW-1:0] memoryWrData,
   output logic [AW-1:0] memoryAddr,
   output logic          memoryWrite,
   output logic          memoryRead,
   output logic          memoryLastWrite,
   output logic          capturing
);

   localparam int CNTW = CW + 2;

   state_t        state_q;
   logic [CW-1:0] readField_q;
   logic [CW-1:0] delayField_q;
   logic [AW-1:0] wrPtr_q;
   logic [AW-1:0] wrPtr_d;
   logic [AW-1:0] rdPtr_q;
   logic [AW-1:0] rdStart_d;
   logic          waitFirst_q;

   logic          send_q;
   logic [DW-1:0] memoryWrData_q;
   logic [AW-1:0] memoryAddr_q;
   logic          memoryWrite_q;
   logic          memoryRead_q;
   logic          lastWrite_q;
   logic          capturing_q;

   logic            capActive;
   logic            writeNow;
   logic            abortReq;
   logic            triggerNow;
   logic            delayLast;
   logic            captureEnd;
   logic            delayLoad;
   logic            delayDec;
   logic            delayZero;
   logic [CNTW-1:0] delayLoadValue;
   logic            readLoad;
   logic            readDec;
   logic            readZero;
   logic [CNTW-1:0] readLoadValue;
   logic            waitDone;

   // Decode of the current cycle's events. The trigger sample itself counts
   // toward the post-trigger window, so the delay counter is loaded one lower
   // when run coincides with validIn. The read window start is taken from
   // the write pointer after this cycle's write, so it ends on the newest
   // sample. Abort has priority over both the trigger and the last write.
   always_comb begin
      capActive  = (state_q == ST_SAMPLE) || (state_q == ST_DELAY);
      writeNow   = capActive && validIn;
      wrPtr_d    = wrPtr_q + AW'(writeNow);
`ifdef CAPTURE_CTRL_ABORT_EN
      abortReq   = capActive && finish_now;
`else
      abortReq   = 1'b0;
`endif
      triggerNow = (state_q == ST_SAMPLE) && run && !abortReq;
      delayLast  = (state_q == ST_DELAY) && validIn && delayZero && !abortReq;
      captureEnd = delayLast || abortReq;

      delayLoad      = triggerNow;
      delayLoadValue = CNTW'(windowLength(16'(delayField_q)) - (validIn ? 32'd2 : 32'd1));
      delayDec       = (state_q == ST_DELAY) && validIn && !delayZero;

      rdStart_d     = wrPtr_d - AW'(windowLength(16'(readField_q)));
      readLoad      = captureEnd;
      readLoadValue = CNTW'(windowLength(16'(readField_q)) - 32'd1);
      waitDone      = (state_q == ST_RD_WAIT) && !waitFirst_q && !busy;
      readDec       = waitDone && !readZero;
   end

   capture_cnt #(.W(CNTW)) delayCnt (
      .clock     (clock),
      .reset     (reset),
      .load      (delayLoad),
      .loadValue (delayLoadValue),
      .decrement (delayDec),
      .zero      (delayZero)
   );

   capture_cnt #(.W(CNTW)) readCnt (
      .clock     (clock),
      .reset     (reset),
      .load      (readLoad),
      .loadValue (readLoadValue),
      .decrement (readDec),
      .zero      (readZero)
   );

   // Sequencer with registered outputs. Strobes default low each cycle.
   // memoryRead is registered in RD_REQ and send in RD_SEND, so send lines
   // up with the RAM data returned one cycle after the read strobe. The first
   // RD_WAIT cycle skips busy because the transmitter has not yet had a
   // chance to raise it for the sample just sent. End of capture (delay
   // expiry or abort) overrides whatever the case statement chose.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         readField_q    <= '0;
         delayField_q   <= '0;
         wrPtr_q        <= '0;
         rdPtr_q        <= '0;
         waitFirst_q    <= 1'b0;
         send_q         <= 1'b0;
         memoryWrData_q <= '0;
         memoryAddr_q   <= '0;
         memoryWrite_q  <= 1'b0;
         memoryRead_q   <= 1'b0;
         lastWrite_q    <= 1'b0;
         capturing_q    <= 1'b0;
      end else begin
         memoryWrite_q <= 1'b0;
         memoryRead_q  <= 1'b0;
         send_q        <= 1'b0;
         lastWrite_q   <= 1'b0;

         if (wrSize) begin
            readField_q  <= config_data[CFG_READ_LSB +: CW];
            delayField_q <= config_data[CFG_DELAY_LSB +: CW];
         end

         if (writeNow) begin
            memoryWrite_q  <= 1'b1;
            memoryWrData_q <= dataIn;
            memoryAddr_q   <= wrPtr_q;
         end
         wrPtr_q <= wrPtr_d;

         case (state_q)
            ST_IDLE: begin
               if (arm) begin
                  state_q     <= ST_SAMPLE;
                  capturing_q <= 1'b1;
               end
            end
            ST_SAMPLE: begin
               if (triggerNow) begin
                  state_q <= ST_DELAY;
               end
            end
            ST_DELAY: begin
               state_q <= ST_DELAY;
            end
            ST_RD_REQ: begin
               if (!busy) begin
                  memoryRead_q <= 1'b1;
                  memoryAddr_q <= rdPtr_q;
                  state_q      <= ST_RD_SEND;
               end
            end
            ST_RD_SEND: begin
               send_q      <= 1'b1;
               rdPtr_q     <= rdPtr_q + AW'(1);
               waitFirst_q <= 1'b1;
               state_q     <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               if (waitFirst_q) begin
                  waitFirst_q <= 1'b0;
               end else if (!busy) begin
                  state_q <= readZero ? ST_IDLE : ST_RD_REQ;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase

         if (captureEnd) begin
            state_q     <= ST_RD_REQ;
            capturing_q <= 1'b0;
            rdPtr_q     <= rdStart_d;
            lastWrite_q <= delayLast;
         end
      end
   end

   assign send            = send_q;
   assign memoryWrData    = memoryWrData_q;
   assign memoryAddr      = memoryAddr_q;
   assign memoryWrite     = memoryWrite_q;
   assign memoryRead      = memoryRead_q;
   assign memoryLastWrite = lastWrite_q;
   assign capturing       = capturing_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl
// Scoreboard bench for capture_ctrl (DW=32, AW=6, CW=16). Stimulus pushes the
// expected RAM writes and readback (address, data) pairs into queues; a
// monitor on the falling edge pops and compares whenever the DUT strobes a
// write, a read or send. A small RAM model supplies read data. The abort
// scenario is built only when CAPTURE_CTRL_ABORT_EN is defined.

module tb_capture_ctrl;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int CW = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          arm = 1'b0;
   logic          run = 1'b0;
   logic          finishNow = 1'b0;
   logic          wrSize = 1'b0;
   logic [31:0]   configData = '0;
   logic          validIn = 1'b0;
   logic [DW-1:0] dataIn = '0;
   logic          busy = 1'b0;
   logic          send;
   logic [DW-1:0] memoryWrData;
   logic [AW-1:0] memoryAddr;
   logic          memoryWrite;
   logic          memoryRead;
   logic          memoryLastWrite;
   logic          capturing;

   always #5 clock = ~clock;

   capture_ctrl #(.DW(DW), .AW(AW), .CW(CW)) dut (
      .clock           (clock),
      .reset           (reset),
      .arm             (arm),
      .run             (run),
`ifdef CAPTURE_CTRL_ABORT_EN
      .finish_now      (finishNow),
`endif
      .wrSize          (wrSize),
      .config_data     (configData),
      .validIn         (validIn),
      .dataIn          (dataIn),
      .busy            (busy),
      .send            (send),
      .memoryWrData    (memoryWrData),
      .memoryAddr      (memoryAddr),
      .memoryWrite     (memoryWrite),
      .memoryRead      (memoryRead),
      .memoryLastWrite (memoryLastWrite),
      .capturing       (capturing)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } wrExp_t;

   wrExp_t        expWrites[$];
   logic [AW-1:0] expRdAddr[$];
   logic [DW-1:0] expRdData[$];
   logic [DW-1:0] tbRam [0:(1<<AW)-1];
   logic [DW-1:0] rdData = '0;
   logic [AW-1:0] expWrPtr = '0;
   int total = 0;
   int bad = 0;
   int sendCount = 0;
   int readCount = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic a, input logic r, input logic v, input logic [DW-1:0] d, input logic f);
      @(posedge clock);
      #1;
      arm = a;
      run = r;
      validIn = v;
      dataIn = d;
      finishNow = f;
   endtask

   task automatic expectWrite(input logic [DW-1:0] d, input logic last);
      wrExp_t e;
      e.addr = expWrPtr;
      e.data = d;
      e.last = last;
      expWrites.push_back(e);
      expWrPtr = expWrPtr + AW'(1);
   endtask

   task automatic expectReads(input int firstAddr, input int firstData);
      for (int i = 0; i < 8; i++) begin
         expRdAddr.push_back(AW'(firstAddr + i));
         expRdData.push_back(DW'(firstData + i));
      end
   endtask

   task automatic feed(input int d, input logic r, input logic last);
      expectWrite(DW'(d), last);
      applyStimulus(1'b0, r, 1'b1, DW'(d), 1'b0);
   endtask

   task automatic configure(input logic [15:0] rField, input logic [15:0] dField);
      @(posedge clock);
      #1;
      wrSize = 1'b1;
      configData = {dField, rField};
      @(posedge clock);
      #1;
      wrSize = 1'b0;
   endtask

   task automatic waitSends(input int target, input string name);
      for (int i = 0; i < 400 && sendCount < target; i++) begin
         @(posedge clock);
      end
      checkOutput(name, 32'(sendCount), 32'(target));
      repeat (12) @(posedge clock);
      checkOutput({name, " no extra sends"}, 32'(sendCount), 32'(target));
      checkOutput({name, " writes left"}, 32'(expWrites.size()), 32'd0);
      checkOutput({name, " reads left"}, 32'(expRdData.size()), 32'd0);
   endtask

   // RAM model: stores writes, returns read data one cycle after the strobe.
   always @(posedge clock) begin
      if (memoryWrite) begin
         tbRam[memoryAddr] <= memoryWrData;
      end
      if (memoryRead) begin
         rdData <= tbRam[memoryAddr];
      end
   end

   // Monitor: compares every DUT strobe against the scoreboard queues.
   always @(negedge clock) begin : monitor
      wrExp_t        e;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      if (!reset) begin
         if (memoryWrite) begin
            if (expWrites.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected write: got addr %0h data %0h expected none", memoryAddr, memoryWrData);
            end else begin
               e = expWrites.pop_front();
               checkOutput("write addr", 32'(memoryAddr), 32'(e.addr));
               checkOutput("write data", 32'(memoryWrData), 32'(e.data));
               checkOutput("write last", 32'(memoryLastWrite), 32'(e.last));
            end
         end else if (memoryLastWrite) begin
            total++;
            bad++;
            $display("[TB] FAIL stray last: got memoryLastWrite 1 expected 0");
         end
         if (memoryRead) begin
            readCount++;
            if (expRdAddr.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected read: got addr %0h expected none", memoryAddr);
            end else begin
               a = expRdAddr.pop_front();
               checkOutput("read addr", 32'(memoryAddr), 32'(a));
            end
         end
         if (send) begin
            sendCount++;
            if (expRdData.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected send: got data %0h expected none", rdData);
            end else begin
               d = expRdData.pop_front();
               checkOutput("send data", 32'(rdData), 32'(d));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int rdBase;

      // Reset state.
      repeat (3) @(posedge clock);
      #2;
      checkOutput("reset send", 32'(send), 32'd0);
      checkOutput("reset write", 32'(memoryWrite), 32'd0);
      checkOutput("reset read", 32'(memoryRead), 32'd0);
      checkOutput("reset last", 32'(memoryLastWrite), 32'd0);
      checkOutput("reset capturing", 32'(capturing), 32'd0);
      checkOutput("reset addr", 32'(memoryAddr), 32'd0);
      checkOutput("reset wrdata", 32'(memoryWrData), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Basic capture: R=1, D=0; samples 0..13, trigger on 10, readback 6..13.
      $display("[TB] basic capture");
      configure(16'd1, 16'd0);
      expectReads(6, 6);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 10; i++) feed(i, 1'b0, 1'b0);
      feed(10, 1'b1, 1'b0);
      feed(11, 1'b0, 1'b0);
      feed(12, 1'b0, 1'b0);
      feed(13, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      waitSends(8, "basic sends");

      // Busy stall: samples 100..113 at addresses 14..27, readback 106..113.
      $display("[TB] busy stall");
      base = sendCount;
      rdBase = readCount;
      expectReads(20, 106);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 100; i < 110; i++) feed(i, 1'b0, 1'b0);
      feed(110, 1'b1, 1'b0);
      feed(111, 1'b0, 1'b0);
      feed(112, 1'b0, 1'b0);
      feed(113, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (send) break;
      end
      checkOutput("stall first send", 32'(send), 32'd1);
      @(posedge clock);
      #1;
      busy = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      checkOutput("stall reads while busy", 32'(readCount - rdBase), 32'd1);
      busy = 1'b0;
      waitSends(base + 8, "stall sends");

      // Arm and run together: run ignored, capture stays open.
      $display("[TB] arm+run same cycle");
      base = sendCount;
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
      for (int i = 200; i < 205; i++) feed(i, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      repeat (5) @(posedge clock);
      #2;
      checkOutput("armrun capturing", 32'(capturing), 32'd1);
      checkOutput("armrun no send", 32'(sendCount), 32'(base));
      checkOutput("armrun writes done", 32'(expWrites.size()), 32'd0);

      // Trigger now, then reset asynchronously while in DELAY with a write out.
      $display("[TB] reset mid-delay");
      feed(205, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, DW'(206), 1'b0);
      @(posedge clock);
      #1;
      validIn = 1'b0;
      #1;
      checkOutput("write before reset", 32'(memoryWrite), 32'd1);
      checkOutput("capturing before reset", 32'(capturing), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("async reset write", 32'(memoryWrite), 32'd0);
      checkOutput("async reset capturing", 32'(capturing), 32'd0);
      checkOutput("async reset addr", 32'(memoryAddr), 32'd0);
      checkOutput("async reset wrdata", 32'(memoryWrData), 32'd0);
      checkOutput("async reset last", 32'(memoryLastWrite), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      expWrPtr = '0;
      applyStimulus(1'b0, 1'b0, 1'b1, DW'(32'h55), 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      @(posedge clock);
      #2;
      checkOutput("idle after reset capturing", 32'(capturing), 32'd0);
      checkOutput("idle drops sample", 32'(memoryWrite), 32'd0);

      // Wrap: R=1, D=1; 70 pre-trigger samples wrap 63->0, readback 370..377.
      $display("[TB] wrap");
      configure(16'd1, 16'd1);
      base = sendCount;
      expectReads(6, 370);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 300; i < 370; i++) feed(i, 1'b0, 1'b0);
      feed(370, 1'b1, 1'b0);
      for (int i = 371; i < 377; i++) feed(i, 1'b0, 1'b0);
      feed(377, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      waitSends(base + 8, "wrap sends");

`ifdef CAPTURE_CTRL_ABORT_EN
      // Abort after 2 of 8 post-trigger samples; window ends at address 25.
      $display("[TB] abort");
      base = sendCount;
      expectReads(18, 404);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 400; i < 410; i++) feed(i, 1'b0, 1'b0);
      feed(410, 1'b1, 1'b0);
      feed(411, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checkOutput("abort capturing", 32'(capturing), 32'd0);
      @(posedge clock);
      #2;
      checkOutput("abort read strobe", 32'(memoryRead), 32'd1);
      waitSends(base + 8, "abort sends");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
